// File: rtl/data_mem_dumper_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_dumper_if
// Brief    : Memory read port and tagged output stream of the data-memory dumper.
// Revision : 1.0
// ============================================================================
interface data_mem_dumper_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output mem_re, mem_addr,
        input  mem_rdata,
        output out_valid, out_data, out_addr,
        input  out_ready
    );

    modport slave (
        input  mem_re, mem_addr,
        output mem_rdata,
        input  out_valid, out_data, out_addr,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_dumper.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_dumper
// Brief    : Scans a word range of data memory and streams each word, tagged
//            with its address, over a valid/ready port. Define
//            DUMP_CHECKSUM_EN to enable the running checksum of sent words.
// Revision : 1.0
// ============================================================================
module data_mem_dumper #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    data_mem_dumper_if.master bus
);
    localparam int c_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_busy;
    logic                r_done;
    logic                r_pend;
    logic [ADDR_W-1:0]   r_pend_addr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [DATA_W-1:0]   r_buf_data [BUF_DEPTH];
    logic [ADDR_W-1:0]   r_buf_addr [BUF_DEPTH];

    logic                w_valid;
    logic                w_pop;
    logic                w_issue;
    logic                w_drained;
    logic [c_CNT_W:0]    w_used;
    logic [c_CNT_W:0]    w_limit;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.out_ready;

    // A slot being popped this cycle counts as free, which keeps one word per
    // cycle flowing with only two buffer entries.
    assign w_used    = {1'b0, r_count} + (c_CNT_W + 1)'(r_pend);
    assign w_limit   = c_DEPTH + (c_CNT_W + 1)'(w_pop);
    assign w_issue   = (r_state == S_READ) && (w_used < w_limit);
    assign w_drained = (r_count == c_CNT_W'(w_pop)) && !r_pend;

    assign bus.mem_re    = w_issue;
    assign bus.mem_addr  = r_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? r_buf_data[r_rd_ptr] : '0;
    assign bus.out_addr  = w_valid ? r_buf_addr[r_rd_ptr] : '0;
    assign busy          = r_busy;
    assign done          = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= base_addr;
                        r_remaining <= length;
                        r_busy      <= 1'b1;
                        // An empty range passes straight through the drain
                        // check, so done lands two cycles after start.
                        r_state     <= (length == '0) ? S_DRAIN : S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_remaining <= r_remaining - (ADDR_W + 1)'(1);
                        if (r_remaining == (ADDR_W + 1)'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drained) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after the strobe and is pushed with its address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_pend      <= w_issue;
            r_pend_addr <= r_addr;
            if (r_pend) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(r_pend) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (r_pend) begin
            r_buf_data[r_wr_ptr] <= bus.mem_rdata;
            r_buf_addr[r_wr_ptr] <= r_pend_addr;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + bus.out_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_dumper
// Brief    : Self-checking bench for data_mem_dumper with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_data_mem_dumper;
    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 32;
    localparam int BUF_DEPTH   = 2;
    localparam int c_MEM_WORDS = 1 << ADDR_W;
`ifdef DUMP_CHECKSUM_EN
    localparam bit c_CS_EN = 1'b1;
`else
    localparam bit c_CS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;

    data_mem_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    data_mem_dumper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] mem [c_MEM_WORDS];
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [DATA_W-1:0] exp_data_q [$];
    logic [DATA_W-1:0] exp_sum;
    logic [ADDR_W-1:0] issue_base;
    int  issue_len, issued, hs_count;
    int  start_cyc = 0, done_cyc, first_hs_cyc, last_hs_cyc;
    bit  expect_done = 1'b0, done_seen, valid_seen;
    bit  prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;
    bit  ready_rand = 1'b0;
    bit  ready_val = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: garbage on idle cycles so a mistimed capture shows up.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        else            bus.mem_rdata <= DATA_W'($urandom);
    end

    always @(posedge clk) begin
        #2;
        bus.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_val;
    end

    always @(negedge clk) begin
        int rel;
        logic [ADDR_W-1:0] a_exp;
        if (rst) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            expect_done = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            rel = cyc - start_cyc;
            chk("busy", busy, expect_done && (rel >= 1) && !done);
            if (bus.mem_re) begin
                a_exp = issue_base + ADDR_W'(issued);
                chk("mem_addr", bus.mem_addr, a_exp);
                issued++;
                chk("read_count_le_len", issued <= issue_len, 1);
            end
            if (bus.out_valid) valid_seen = 1'b1;
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_addr", bus.out_addr, prev_addr);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: actual addr=0x%0h data=0x%0h required none",
                             bus.out_addr, bus.out_data);
                end else begin
                    chk("out_addr", bus.out_addr, exp_addr_q.pop_front());
                    chk("out_data", bus.out_data, exp_data_q.pop_front());
                end
                hs_count++;
                if (hs_count == 1) first_hs_cyc = rel;
                last_hs_cyc = rel;
            end
            if (bus.mem_re) chk("outstanding_le_depth", (issued - hs_count) <= BUF_DEPTH, 1);
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_addr  = bus.out_addr;
            if (done) begin
                chk("done_expected", expect_done, 1);
                chk("done_all_words_sent", exp_addr_q.size(), 0);
                chk("checksum_at_done", checksum, c_CS_EN ? exp_sum : '0);
                done_seen   = 1'b1;
                done_cyc    = rel;
                expect_done = 1'b0;
            end
        end
    end

    task automatic start_dump(input logic [ADDR_W-1:0] b, input int n);
        logic [ADDR_W-1:0] a;
        @(posedge clk); #1;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            a = b + ADDR_W'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
            exp_sum = exp_sum + mem[a];
        end
        issue_base   = b;
        issue_len    = n;
        issued       = 0;
        hs_count     = 0;
        first_hs_cyc = -1;
        last_hs_cyc  = -1;
        done_seen    = 1'b0;
        valid_seen   = 1'b0;
        start_cyc    = cyc;
        expect_done  = 1'b1;
        start        = 1'b1;
        base_addr    = b;
        length       = (ADDR_W + 1)'(n);
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        length    = (ADDR_W + 1)'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && !done_seen; k++) @(posedge clk);
        chk("done_within_budget", done_seen, 1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_mem_re"},    bus.mem_re, 0);
        chk({tag, "_mem_addr"},  bus.mem_addr, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"},  bus.out_data, 0);
        chk({tag, "_out_addr"},  bus.out_addr, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_done"},      done, 0);
        chk({tag, "_checksum"},  checksum, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [ADDR_W-1:0] b;
        for (int i = 0; i < c_MEM_WORDS; i++) mem[i] = $urandom;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Sorted array, ready held high.
        for (int i = 0; i < 6; i++) mem[4 + i] = DATA_W'(i + 1);
        ready_val = 1'b1;
        start_dump(11'd4, 6);
        wait_done(40);
        chk("sorted_first_hs_cycle", first_hs_cyc, 3);
        chk("sorted_last_hs_cycle", last_hs_cyc, 8);
        chk("sorted_done_cycle", done_cyc, 9);
        chk("sorted_words", hs_count, 6);
        chk("sorted_checksum_held", checksum, c_CS_EN ? 21 : 0);

        // Zero length.
        start_dump(11'd10, 0);
        wait_done(20);
        chk("zero_done_cycle", done_cyc, 2);
        chk("zero_no_reads", issued, 0);
        chk("zero_no_valid", valid_seen, 0);

        // Address wrap.
        mem[2046] = 32'd10; mem[2047] = 32'd11; mem[0] = 32'd12; mem[1] = 32'd13;
        start_dump(11'd2046, 4);
        wait_done(40);
        chk("wrap_words", hs_count, 4);
        chk("wrap_checksum", checksum, c_CS_EN ? 46 : 0);

        // Backpressure.
        ready_val = 1'b0;
        start_dump(11'd200, 5);
        repeat (10) @(posedge clk);
        #1;
        chk("stall_reads_le_2", issued <= 2, 1);
        chk("stall_no_handshake", hs_count, 0);
        chk("stall_valid_held", bus.out_valid, 1);
        ready_val = 1'b1;
        wait_done(60);
        chk("stall_words", hs_count, 5);

        // Reset after the second handshake of a six-word dump.
        start_dump(11'd4, 6);
        for (int k = 0; k < 50 && hs_count < 2; k++) @(posedge clk);
        chk("midreset_two_handshakes", hs_count, 2);
        #1;
        rst = 1'b1;
        ready_val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        repeat (10) @(posedge clk);
        chk("midreset_no_done", done_seen, 0);
        ready_val = 1'b1;
        start_dump(11'd4, 6);
        wait_done(40);
        chk("midreset_redump_words", hs_count, 6);

        // start re-pulsed while busy must be ignored.
        ready_rand = 1'b1;
        start_dump(11'd4, 6);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; base_addr = 11'd100; length = 12'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        chk("busy_start_words", hs_count, 6);

        // Randomized dumps.
        for (int r = 0; r < 12; r++) begin
            b = ADDR_W'($urandom);
            n = $urandom_range(0, 24);
            ready_rand = ($urandom_range(0, 1) == 1);
            ready_val  = 1'b1;
            start_dump(b, n);
            wait_done(500);
            chk("rand_words", hs_count, n);
            if (!ready_rand) chk("rand_done_latency", done_cyc, (n == 0) ? 2 : n + 3);
        end

        ready_rand = 1'b0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
